fifo_write_arbiter: RTL
=======================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (legal range 2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning the width of one write word.
REQ-003 SHALL have parameter MAX_BURST, default 4, meaning the maximum consecutive grants per tenure (legal range 1..255).
REQ-004 SHALL have port write_clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 SHALL have port req, input, NUM_REQ bits: per-requester write request, held until granted.
REQ-007 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH bits: slice i is requester i's word.
REQ-008 SHALL have port write_full, input, 1 bit: full flag from the FIFO write handler.
REQ-009 SHALL have port grant, output, NUM_REQ bits: one-hot; bit i means req_data slice i is consumed this cycle.
REQ-010 SHALL have port write_enable, output, 1 bit: write strobe to the FIFO write handler.
REQ-011 SHALL have port write_data, output, DATA_WIDTH bits: word to the FIFO memory.
REQ-012 SHALL have port owner, output, clog2(NUM_REQ) bits: index of the current or last tenure holder.
REQ-013 SHALL have port busy, output, 1 bit: high while the FSM is in BURST.

Function
REQ-014 SHALL implement the FSM states IDLE and BURST, plus the registers last_owner, owner_q and count (clog2(MAX_BURST+1) bits).
REQ-015 SHALL, in IDLE with |req=1 and write_full=0, grant the first requesting index after last_owner, searching round-robin upward and wrapping from NUM_REQ-1 to 0.
REQ-016 SHALL, on an IDLE grant, set owner_q to the winner and count to 1, and go to BURST (or stay in IDLE if MAX_BURST=1).
REQ-017 SHALL, in BURST with req[owner_q]=1, write_full=0 and count<MAX_BURST, grant owner_q and increment count.
REQ-018 SHALL, on any grant that makes count equal MAX_BURST, set last_owner to owner_q and go to IDLE, so the next cycle re-arbitrates with no bubble.
REQ-019 SHALL, in BURST with req[owner_q]=0, issue no grant, set last_owner to owner_q and go to IDLE (one bubble cycle).
REQ-020 SHALL, while write_full=1, issue no grant in either state, keep state, count and owner_q unchanged, and not move last_owner.
REQ-021 SHALL drive grant combinationally from the current state and inputs, with at most one bit set.
REQ-022 SHALL drive write_enable as the OR of all grant bits, with zero latency.
REQ-023 SHALL drive write_data as the granted req_data slice, and as all zeros when there is no grant.
REQ-024 SHALL drive owner from owner_q, and busy as (state==BURST).
REQ-025 SHALL never assert write_enable when write_full=1 in the same cycle.

Reset
REQ-026 SHALL, on reset=1 at a clock edge, set state=IDLE, count=0, owner_q=0 and last_owner=NUM_REQ-1, so requester 0 wins first.
REQ-027 SHALL force grant, write_enable and write_data to 0 in any cycle where reset=1, including mid-burst.
REQ-028 SHALL drive owner=0 and busy=0 after reset.

Structure
REQ-029 SHALL place the FSM state encoding (IDLE=0, BURST=1) in the shared package fifo_pkg, alongside the ADDRESS_SIZE default.
REQ-030 SHALL implement the round-robin search as one combinational sub-module rr_pick (inputs: req, last_owner; outputs: winner index and a valid flag).
REQ-031 SHALL connect to the FIFO write handler only through write_enable, write_data and write_full.

Verification (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4 unless stated)
REQ-032 SHALL cover: reset, then req=4'b1111 held, write_full=0 -> grant owners 0,0,0,0,1,1,1,1,2,2,2,2,3,... with write_enable high every cycle.
REQ-033 SHALL cover: req[0] high for one cycle with slice 0 = 8'hA5 -> grant=4'b0001, write_enable=1, write_data=8'hA5 that cycle; next cycle no grant, busy falls.
REQ-034 SHALL cover: owner 1 at count=2, then write_full=1 for 3 cycles with req=4'b0010 held -> no grant and owner=1 for 3 cycles, then exactly 2 more grants, then IDLE.
REQ-035 SHALL cover: IDLE with req=4'b0110 and write_full=1 for 5 cycles -> no grant; when full drops, requester 1 wins (last_owner=3 after reset).
REQ-036 SHALL cover: reset=1 mid-burst at owner 2, count 3 -> grant=0 that cycle; next cycle state IDLE, and with req=4'b1111 requester 0 wins.
REQ-037 SHALL cover: MAX_BURST=1 with req=4'b1010 held -> grants alternate 1,3,1,3 every cycle with no bubbles and busy held 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side blocks: arbiter FSM encoding,
// the default FIFO address size and the round-robin distance helper.
package fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int ADDRESS_SIZE = 4;

  // Search order position of idx when the previous holder was last:
  // last+1 is position 0, last itself is position n-1.
  function automatic int rr_distance(input int idx, input int last, input int n);
    return (idx + n - 1 - last) % n;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index
// strictly after last_owner, wrapping from NUM_REQ-1 back to 0.
module rr_pick
  import fifo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  // NOTE: every variable assigned in always_comb gets a default first;
  // a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    int best_d;
    int d;
    winner = '0;
    valid  = 1'b0;
    best_d = NUM_REQ;
    d      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        d = rr_distance(i, int'(last_owner), NUM_REQ);
        if (d < best_d) begin
          best_d = d;
          winner = IDX_W'(i);
          valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter in front of a FIFO write handler: grants bursts
// of up to MAX_BURST words per requester and stalls cleanly on write_full.
module fifo_write_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          write_clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          write_full,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          write_enable,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_BURST);
  localparam logic [CW-1:0] CNT_LAST   = CW'(MAX_BURST - 1);
  localparam logic [OW-1:0] LAST_RESET = OW'(NUM_REQ - 1);

  arb_state_e    state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] last_owner_q, last_owner_d;
  logic [CW-1:0] count_q, count_d;

  logic [OW-1:0] pick_idx;
  logic          pick_vld;
  logic [OW-1:0] gnt_idx;
  logic          gnt_vld;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (OW)
  ) u_rr_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .winner     (pick_idx),
    .valid      (pick_vld)
  );

  // Grant decision is combinational so the word is consumed in the same
  // cycle; reset and full both suppress it outright.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = owner_q;
    if (!reset && !write_full) begin
      if (state_q == IDLE) begin
        gnt_vld = pick_vld;
        gnt_idx = pick_idx;
      end else if (req[owner_q] && (count_q < CNT_MAX)) begin
        gnt_vld = 1'b1;
      end
    end
  end

  assign grant        = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign write_enable = |grant;

  always_comb begin
    write_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        write_data = write_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    count_d      = count_q;
    if (!write_full) begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            owner_d = pick_idx;
            count_d = CW'(1);
            // A one-word tenure ends on its own grant; re-arbitrate next cycle.
            if (MAX_BURST == 1) begin
              last_owner_d = pick_idx;
            end else begin
              state_d = BURST;
            end
          end
        end
        BURST: begin
          if (gnt_vld) begin
            count_d = count_q + 1'b1;
            if (count_q == CNT_LAST) begin
              last_owner_d = owner_q;
              state_d      = IDLE;
            end
          end else begin
            last_owner_d = owner_q;
            state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge write_clock) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= LAST_RESET;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign owner = owner_q;
  assign busy  = (state_q == BURST);

endmodule
